// File: rtl/raster_pkg.sv
// Shared raster timing, game-space constants and stage payload types for the VGA mapping path.
package raster_pkg;

  typedef enum logic [1:0] {
    ROT_0   = 2'd0,
    ROT_90  = 2'd1,
    ROT_180 = 2'd2,
    ROT_270 = 2'd3
  } rot_mode_t;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned SUB_W = 2;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_TOTAL_DEF  = 800;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_TOTAL_DEF  = 525;

  localparam int unsigned GAME_W_DEF = 240;
  localparam int unsigned GAME_H_DEF = 320;
  localparam int unsigned ADDR_W_DEF = 17;

  // One pipeline slot: raster position plus its mapped game coordinates.
  typedef struct packed {
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             active;
    logic             frame_start;
    logic             in_game;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } map_stage_t;

endpackage

// File: rtl/raster_counter.sv
// S0 raster counters: pixel/line counts plus divider-free SCALE sub-counters for scaled u/v.
module raster_counter
  import raster_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned SCALE   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] hc_o,
  output logic [CNT_W-1:0] vc_o,
  output logic [CNT_W-1:0] u_o,
  output logic [CNT_W-1:0] v_o,
  output logic             line_wrap_c,
  output logic             frame_wrap_c
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [SUB_W-1:0] S_LAST = SUB_W'(SCALE - 1);

  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d, u_q, u_d, v_q, v_d;
  logic [SUB_W-1:0] hs_q, hs_d, vs_q, vs_d;

  assign line_wrap_c  = pix_en_i && (hc_q == H_LAST);
  assign frame_wrap_c = line_wrap_c && (vc_q == V_LAST);

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    hs_d = hs_q;
    vs_d = vs_q;
    u_d  = u_q;
    v_d  = v_q;
    if (line_wrap_c) begin
      hc_d = '0;
      hs_d = '0;
      u_d  = '0;
      if (frame_wrap_c) begin
        vc_d = '0;
        vs_d = '0;
        v_d  = '0;
      end else begin
        vc_d = vc_q + 1'b1;
        if (vs_q == S_LAST) begin
          vs_d = '0;
          v_d  = v_q + 1'b1;
        end else begin
          vs_d = vs_q + 1'b1;
        end
      end
    end else if (pix_en_i) begin
      hc_d = hc_q + 1'b1;
      if (hs_q == S_LAST) begin
        hs_d = '0;
        u_d  = u_q + 1'b1;
      end else begin
        hs_d = hs_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q <= '0;
      vc_q <= '0;
      hs_q <= '0;
      vs_q <= '0;
      u_q  <= '0;
      v_q  <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      u_q  <= u_d;
      v_q  <= v_d;
    end
  end

  assign hc_o = hc_q;
  assign vc_o = vc_q;
  assign u_o  = u_q;
  assign v_o  = v_q;

endmodule

// File: rtl/raster_mapper.sv
// Raster-to-game-space mapper: S0 counters, S1 quarter-turn rotate + range check, S2 address/outputs.
module raster_mapper
  import raster_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned H_TOTAL   = H_TOTAL_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned V_TOTAL   = V_TOTAL_DEF,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned GAME_W    = GAME_W_DEF,
  parameter int unsigned GAME_H    = GAME_H_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned ROT_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [1:0]        rot_mode,
  output logic [CNT_W-1:0]  hc,
  output logic [CNT_W-1:0]  vc,
  output logic              active,
  output logic              frame_start,
  output logic [CNT_W-1:0]  xpos,
  output logic [CNT_W-1:0]  ypos,
  output logic              in_game,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned MAP_W = CNT_W + 2;

  localparam logic [CNT_W-1:0]        H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]        V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic signed [MAP_W-1:0] GW_S   = MAP_W'(GAME_W);
  localparam logic signed [MAP_W-1:0] GH_S   = MAP_W'(GAME_H);
  localparam logic signed [MAP_W-1:0] GW_M1  = MAP_W'(GAME_W - 1);
  localparam logic signed [MAP_W-1:0] GH_M1  = MAP_W'(GAME_H - 1);
  localparam logic [ADDR_W-1:0]       GW_A   = ADDR_W'(GAME_W);
  localparam rot_mode_t               MODE_RST = rot_mode_t'(2'(ROT_RESET));

  logic [CNT_W-1:0] hc_s0, vc_s0, u_s0, v_s0;
  logic             line_wrap_c, frame_wrap_c;

  raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .SCALE   (SCALE)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .pix_en_i     (pix_en),
    .hc_o         (hc_s0),
    .vc_o         (vc_s0),
    .u_o          (u_s0),
    .v_o          (v_s0),
    .line_wrap_c  (line_wrap_c),
    .frame_wrap_c (frame_wrap_c)
  );

  rot_mode_t         mode_q, mode_d;
  map_stage_t        s1_q, s1_d, out_q;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic signed [MAP_W-1:0] us_c, vs_c, x_c, y_c;
  logic                    active_c, in_game_c;

  // The mode only changes on the strobe that takes the counters to (0,0).
  assign mode_d = frame_wrap_c ? rot_mode_t'(rot_mode) : mode_q;

  always_comb begin
    us_c = MAP_W'(u_s0);
    vs_c = MAP_W'(v_s0);
    x_c  = us_c;
    y_c  = vs_c;
    case (mode_q)
      ROT_0:   begin x_c = us_c;         y_c = vs_c;         end
      ROT_90:  begin x_c = GW_M1 - vs_c; y_c = us_c;         end
      ROT_180: begin x_c = GW_M1 - us_c; y_c = GH_M1 - vs_c; end
      ROT_270: begin x_c = vs_c;         y_c = GH_M1 - us_c; end
    endcase
    active_c  = (hc_s0 < H_ACT) && (vc_s0 < V_ACT);
    in_game_c = active_c && !x_c[MAP_W-1] && (x_c < GW_S)
                         && !y_c[MAP_W-1] && (y_c < GH_S);

    s1_d             = '0;
    s1_d.hc          = hc_s0;
    s1_d.vc          = vc_s0;
    s1_d.active      = active_c;
    s1_d.frame_start = (hc_s0 == '0) && (vc_s0 == '0);
    s1_d.in_game     = in_game_c;
    s1_d.x           = in_game_c ? x_c[CNT_W-1:0] : '0;
    s1_d.y           = in_game_c ? y_c[CNT_W-1:0] : '0;
  end

  // Off-game slots carry x = y = 0, so the address is forced to 0 as well.
  assign addr_d = ADDR_W'(s1_q.y) * GW_A + ADDR_W'(s1_q.x);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= MODE_RST;
      s1_q   <= '0;
      out_q  <= '0;
      addr_q <= '0;
    end else begin
      mode_q <= mode_d;
      if (pix_en) begin
        s1_q   <= s1_d;
        out_q  <= s1_q;
        addr_q <= addr_d;
      end
    end
  end

  assign hc          = out_q.hc;
  assign vc          = out_q.vc;
  assign active      = out_q.active;
  assign frame_start = out_q.frame_start;
  assign xpos        = out_q.x;
  assign ypos        = out_q.y;
  assign in_game     = out_q.in_game;
  assign addr        = addr_q;

endmodule

// File: tb/tb_raster_mapper.sv
// Bench for raster_mapper on a reduced 80x53 raster: random modes and strobes against a pixel-level model.
module tb_raster_mapper;

  localparam int HA = 64;
  localparam int HT = 80;
  localparam int VA = 48;
  localparam int VT = 53;
  localparam int SC = 2;
  localparam int GW = 24;
  localparam int GH = 32;
  localparam int AW = 10;
  localparam int RR = 1;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_en = 1'b0;
  logic [1:0]    rot_mode = 2'd0;
  logic [9:0]    hc, vc, xpos, ypos;
  logic          active, frame_start, in_game;
  logic [AW-1:0] addr;

  raster_mapper #(
    .H_ACTIVE (HA), .H_TOTAL (HT), .V_ACTIVE (VA), .V_TOTAL (VT),
    .SCALE (SC), .GAME_W (GW), .GAME_H (GH), .ADDR_W (AW), .ROT_RESET (RR)
  ) dut (
    .clk (clk), .rst (rst), .pix_en (pix_en), .rot_mode (rot_mode),
    .hc (hc), .vc (vc), .active (active), .frame_start (frame_start),
    .xpos (xpos), .ypos (ypos), .in_game (in_game), .addr (addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hc; int vc; int x; int y; int addr; int mode;
    bit active; bit fs; bit ig;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   sc = 0;
  int   pos_h = 0;
  int   pos_v = 0;
  int   frame_mode = RR;
  exp_t q[$];
  exp_t cur;
  bit   measure_fs = 1'b0;
  int   fs_run = 0;
  bit   found;

  function automatic exp_t zero_exp();
    exp_t e;
    e.hc = 0; e.vc = 0; e.x = 0; e.y = 0; e.addr = 0; e.mode = 0;
    e.active = 1'b0; e.fs = 1'b0; e.ig = 1'b0;
    return e;
  endfunction

  // Expected outputs for raster position (h,v) under rotation m.
  function automatic exp_t calc(int h, int v, int m);
    exp_t e;
    int u, w, x, y;
    u = h / SC;
    w = v / SC;
    case (m)
      0:       begin x = u;          y = w;          end
      1:       begin x = GW - 1 - w; y = u;          end
      2:       begin x = GW - 1 - u; y = GH - 1 - w; end
      default: begin x = w;          y = GH - 1 - u; end
    endcase
    e.hc = h; e.vc = v; e.mode = m;
    e.active = (h < HA) && (v < VA);
    e.fs = (h == 0) && (v == 0);
    e.ig = e.active && x >= 0 && x < GW && y >= 0 && y < GH;
    if (!e.ig) begin x = 0; y = 0; end
    e.x = x; e.y = y; e.addr = y * GW + x;
    return e;
  endfunction

  function automatic int plan(int s);
    if (s % FRAME == 0) begin
      case (s / FRAME)
        1: return 0;
        2: return 2;
        3: return 3;
        4: return 1;
        default: return int'($urandom_range(0, 3));
      endcase
    end
    if (s > 2 * FRAME + FRAME / 2 && s < 3 * FRAME) return 3;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(zero_exp());
    cur = zero_exp();
    pos_h = 0; pos_v = 0; frame_mode = RR; sc = 0;
  endtask

  task automatic model_strobe(input int m);
    q.push_back(calc(pos_h, pos_v, frame_mode));
    pos_h++;
    if (pos_h == HT) begin
      pos_h = 0;
      pos_v++;
      if (pos_v == VT) pos_v = 0;
    end
    if (pos_h == 0 && pos_v == 0) frame_mode = m;
    cur = q.pop_front();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (model h=%0d v=%0d)", tag, obs, exp, cur.hc, cur.vc);
    end
  endtask

  task automatic check_all();
    chk("hc", 32'(hc), 32'(cur.hc));
    chk("vc", 32'(vc), 32'(cur.vc));
    chk("active", 32'(active), 32'(cur.active));
    chk("frame_start", 32'(frame_start), 32'(cur.fs));
    chk("xpos", 32'(xpos), 32'(cur.x));
    chk("ypos", 32'(ypos), 32'(cur.y));
    chk("in_game", 32'(in_game), 32'(cur.ig));
    chk("addr", 32'(addr), 32'(cur.addr));
    if (cur.fs && cur.mode == 1) begin
      chk("m1_origin_x", 32'(xpos), 23);
      chk("m1_origin_y", 32'(ypos), 0);
      chk("m1_origin_addr", 32'(addr), 23);
      chk("m1_origin_in_game", 32'(in_game), 1);
    end
    if (cur.hc == 63 && cur.vc == 47 && cur.mode == 1) begin
      chk("m1_corner_x", 32'(xpos), 0);
      chk("m1_corner_y", 32'(ypos), 31);
      chk("m1_corner_addr", 32'(addr), 744);
    end
    if (cur.hc == 64 && cur.vc == 47 && cur.mode == 1) begin
      chk("m1_blank_active", 32'(active), 0);
      chk("m1_blank_in_game", 32'(in_game), 0);
      chk("m1_blank_addr", 32'(addr), 0);
    end
    if (cur.mode == 0 && cur.vc == 0 && cur.hc == 46) chk("m0_edge_in", 32'(in_game), 1);
    if (cur.mode == 0 && cur.vc == 0 && cur.hc == 48) chk("m0_edge_out", 32'(in_game), 0);
    if (cur.mode == 0 && cur.vc == 2 && cur.hc == 0) chk("m0_row1_y", 32'(ypos), 1);
    if (cur.fs && cur.mode == 2) begin
      chk("m2_origin_x", 32'(xpos), 23);
      chk("m2_origin_y", 32'(ypos), 31);
      chk("m2_origin_addr", 32'(addr), 767);
    end
    if (cur.fs && cur.mode == 3) begin
      chk("m3_origin_x", 32'(xpos), 0);
      chk("m3_origin_y", 32'(ypos), 31);
    end
    if (measure_fs) begin
      if (frame_start === 1'b1) fs_run++;
      else if (fs_run > 0) begin
        chk("frame_start_len", 32'(fs_run), 4);
        fs_run = 0;
      end
    end
  endtask

  task automatic tick(input bit en);
    logic [1:0] m;
    m = en ? 2'(plan(sc + 1)) : 2'($urandom_range(0, 3));
    @(negedge clk);
    pix_en = en;
    rot_mode = m;
    @(posedge clk);
    #1;
    if (en) begin
      sc++;
      model_strobe(int'(m));
    end
    check_all();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_hc"}, 32'(hc), 0);
    chk({pfx, "_vc"}, 32'(vc), 0);
    chk({pfx, "_active"}, 32'(active), 0);
    chk({pfx, "_frame_start"}, 32'(frame_start), 0);
    chk({pfx, "_xpos"}, 32'(xpos), 0);
    chk({pfx, "_ypos"}, 32'(ypos), 0);
    chk({pfx, "_in_game"}, 32'(in_game), 0);
    chk({pfx, "_addr"}, 32'(addr), 0);
  endtask

  initial begin
    model_reset();
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick(1'b0);

    // Four full-rate frames: modes 1, 0, 2 (switched to 3 mid-frame), 3.
    repeat (4 * FRAME) tick(1'b1);

    // 1-in-4 strobe duty across a frame boundary.
    fs_run = 0;
    measure_fs = 1'b1;
    repeat (FRAME + 10) begin
      repeat (3) tick(1'b0);
      tick(1'b1);
    end
    measure_fs = 1'b0;

    // Random strobes until the outputs show (30,10), then reset asynchronously.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick(1'($urandom_range(0, 1)));
      if (cur.hc == 30 && cur.vc == 10) found = 1'b1;
    end
    chk("reach_reset_point", 32'(found), 1);

    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    repeat (2) begin
      @(negedge clk);
      pix_en = 1'b1;
      @(posedge clk);
      #1 check_all();
    end
    @(negedge clk);
    rst = 1'b1;
    pix_en = 1'b0;
    #1 check_all();

    tick(1'b1);
    chk("post_rst_fs_1st", 32'(frame_start), 0);
    tick(1'b1);
    chk("post_rst_fs_2nd", 32'(frame_start), 1);
    chk("post_rst_mode_x", 32'(xpos), 23);
    repeat (300) tick(1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
